// File: rtl/miniproject_motor_pwm.sv
// Avalon-MM slave producing a period-aligned forward/reverse PWM pair for the motor H-bridge,
// with boundary-paced duty ramping, a dead period on direction change and a period-end interrupt.
module miniproject_motor_pwm (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq,
    output logic        pwm_a,
    output logic        pwm_b
);

    logic [3:0]  r_ctrl;
    logic [15:0] r_period;
    logic [15:0] r_duty_tgt;
    logic [15:0] r_ramp_step;
    logic [15:0] r_duty_cur;
    logic [15:0] r_cnt;
    logic        r_dir_act;
    logic        r_dead;
    logic        r_period_done;

    logic        w_wr;
    logic        w_wr_status;
    logic        w_wr_ctrl;
    logic        w_wr_period;
    logic        w_wr_tgt;
    logic        w_wr_step;
    logic [3:0]  w_ctrl_nxt;
    logic        w_run;
    logic        w_boundary;
    logic        w_pwm;
    logic [16:0] w_up;
    logic [16:0] w_dn;
    logic [15:0] w_duty_nxt;
    logic [15:0] w_status;
    logic [15:0] w_rdata;

    assign w_wr        = chipselect && !write_n;
    assign w_wr_status = w_wr && (address == 3'd0);
    assign w_wr_ctrl   = w_wr && (address == 3'd1);
    assign w_wr_period = w_wr && (address == 3'd2);
    assign w_wr_tgt    = w_wr && (address == 3'd3);
    assign w_wr_step   = w_wr && (address == 3'd4);

    // Control value as it will be after this edge; lets a disable or brake act on the write edge.
    assign w_ctrl_nxt = w_wr_ctrl ? writedata[3:0] : r_ctrl;

    assign w_run      = r_ctrl[1];
    assign w_boundary = w_run && (r_cnt == r_period);
    assign w_pwm      = (r_cnt < r_duty_cur);

    assign w_up = {1'b0, r_duty_cur} + {1'b0, r_ramp_step};
    assign w_dn = {1'b0, r_duty_cur} - {1'b0, r_ramp_step};

    always_comb begin
        w_duty_nxt = r_duty_tgt;
        if (r_ramp_step != 16'd0) begin
            if (r_duty_cur < r_duty_tgt) begin
                if (w_up < {1'b0, r_duty_tgt})
                    w_duty_nxt = w_up[15:0];
            end else if (r_duty_cur > r_duty_tgt) begin
                // w_dn[16] set means the step overshot below zero
                if (!w_dn[16] && (w_dn[15:0] > r_duty_tgt))
                    w_duty_nxt = w_dn[15:0];
            end
        end
    end

    assign w_status = {13'd0, (r_duty_cur != r_duty_tgt), w_run, r_period_done};

    always_comb begin
        w_rdata = 16'd0;
        case (address)
            3'd0:    w_rdata = w_status;
            3'd1:    w_rdata = {12'd0, r_ctrl};
            3'd2:    w_rdata = r_period;
            3'd3:    w_rdata = r_duty_tgt;
            3'd4:    w_rdata = r_ramp_step;
            3'd5:    w_rdata = r_duty_cur;
            default: w_rdata = 16'd0;
        endcase
    end

    assign irq = r_period_done && r_ctrl[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl        <= 4'd0;
            r_period      <= 16'd49999;
            r_duty_tgt    <= 16'd0;
            r_ramp_step   <= 16'd0;
            r_duty_cur    <= 16'd0;
            r_cnt         <= 16'd0;
            r_dir_act     <= 1'b0;
            r_dead        <= 1'b0;
            r_period_done <= 1'b0;
            readdata      <= 16'd0;
            pwm_a         <= 1'b0;
            pwm_b         <= 1'b0;
        end else begin
            readdata <= w_rdata;
            r_ctrl   <= w_ctrl_nxt;
            if (w_wr_period) r_period    <= writedata;
            if (w_wr_tgt)    r_duty_tgt  <= writedata;
            if (w_wr_step)   r_ramp_step <= writedata;

            if (!w_run || !w_ctrl_nxt[1] || w_wr_period || w_boundary)
                r_cnt <= 16'd0;
            else
                r_cnt <= r_cnt + 16'd1;

            if (w_boundary) begin
                r_duty_cur <= w_duty_nxt;
                r_dir_act  <= r_ctrl[2];
                r_dead     <= (r_ctrl[2] != r_dir_act);
            end

            if (w_wr_status)
                r_period_done <= 1'b0;
            else if (w_boundary)
                r_period_done <= 1'b1;

            if (!w_run || !w_ctrl_nxt[1]) begin
                pwm_a <= 1'b0;
                pwm_b <= 1'b0;
            end else if (w_ctrl_nxt[3]) begin
                pwm_a <= 1'b1;
                pwm_b <= 1'b1;
            end else if (r_dead) begin
                pwm_a <= 1'b0;
                pwm_b <= 1'b0;
            end else begin
                pwm_a <= w_pwm && !r_dir_act;
                pwm_b <= w_pwm && r_dir_act;
            end
        end
    end

endmodule

// File: tb/tb_miniproject_motor_pwm.sv
// Directed bench for miniproject_motor_pwm: register map, PWM shape, ramping, direction dead period,
// brake, boundary cases, mid-period PERIOD/enable changes and asynchronous reset.
module tb_miniproject_motor_pwm;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;
    logic        pwm_a;
    logic        pwm_b;

    int n_checks = 0;
    int n_err    = 0;
    int edge_cnt = 0;
    int e0;
    int w0;

    miniproject_motor_pwm dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .pwm_a      (pwm_a),
        .pwm_b      (pwm_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the write is sampled on the next rising edge.
    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input string tag, input logic [15:0] exp);
        address = a;
        @(negedge clk);
        chk(tag, readdata, exp);
    endtask

    task automatic wait_until(input int t);
        while (edge_cnt < t) @(negedge clk);
    endtask

    logic ea, eb;
    logic [15:0] ramp_exp [1:9];

    initial begin
        ramp_exp[1] = 16'd30; ramp_exp[2] = 16'd60; ramp_exp[3] = 16'd90;
        ramp_exp[4] = 16'd100; ramp_exp[5] = 16'd100; ramp_exp[6] = 16'd70;
        ramp_exp[7] = 16'd40; ramp_exp[8] = 16'd10; ramp_exp[9] = 16'd0;

        reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 16'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // reset state
        chk("rst_pwm_a", {15'd0, pwm_a}, 16'd0);
        chk("rst_pwm_b", {15'd0, pwm_b}, 16'd0);
        chk("rst_irq", {15'd0, irq}, 16'd0);
        rd(3'd0, "rst_status", 16'd0);
        rd(3'd1, "rst_control", 16'd0);
        rd(3'd2, "rst_period", 16'd49999);
        rd(3'd3, "rst_duty_tgt", 16'd0);
        rd(3'd4, "rst_ramp_step", 16'd0);
        rd(3'd5, "rst_duty_cur", 16'd0);
        rd(3'd6, "rst_addr6", 16'd0);
        rd(3'd7, "rst_addr7", 16'd0);

        // basic PWM 3/10, first period at duty 0
        wr(3'd2, 16'd9);
        wr(3'd3, 16'd3);
        wr(3'd1, 16'h2);
        e0 = edge_cnt;
        for (int k = 1; k <= 30; k++) begin
            wait_until(e0 + k);
            ea = (k >= 11) && (((k - 11) % 10) < 3);
            chk($sformatf("basic_a_k%0d", k), {15'd0, pwm_a}, {15'd0, ea});
            chk($sformatf("basic_b_k%0d", k), {15'd0, pwm_b}, 16'd0);
        end
        rd(3'd0, "basic_status", 16'h0003);
        wr(3'd1, 16'h3);
        chk("irq_assert", {15'd0, irq}, 16'd1);
        wr(3'd0, 16'h0);
        chk("irq_clear", {15'd0, irq}, 16'd0);
        wr(3'd3, 16'd0);
        wait_until(e0 + 45);
        rd(3'd5, "duty_to_zero", 16'd0);
        wr(3'd1, 16'h0);

        // ramp up then down
        wr(3'd2, 16'd99);
        wr(3'd4, 16'd30);
        wr(3'd3, 16'd100);
        wr(3'd1, 16'h2);
        e0 = edge_cnt;
        for (int n = 1; n <= 9; n++) begin
            wait_until(e0 + 100 * n + 5);
            rd(3'd5, $sformatf("ramp_n%0d", n), ramp_exp[n]);
            if (n == 3) rd(3'd0, "ramp_busy_set", 16'h0007);
            if (n == 4) rd(3'd0, "ramp_busy_clr", 16'h0003);
            if (n == 5) wr(3'd3, 16'd0);
            if (n == 9) rd(3'd0, "ramp_down_done", 16'h0003);
        end

        // direction change with dead period, then brake
        wr(3'd1, 16'h0);
        wr(3'd4, 16'd0);
        wr(3'd2, 16'd9);
        wr(3'd3, 16'd5);
        wr(3'd1, 16'h2);
        e0 = edge_cnt;
        for (int k = 11; k <= 50; k++) begin
            if (k == 15) wr(3'd1, 16'h6);
            else wait_until(e0 + k);
            if (k <= 20) begin
                ea = ((k - 11) % 10) < 5; eb = 1'b0;
            end else if (k <= 30) begin
                ea = 1'b0; eb = 1'b0;
            end else begin
                ea = 1'b0; eb = ((k - 31) % 10) < 5;
            end
            chk($sformatf("dir_a_k%0d", k), {15'd0, pwm_a}, {15'd0, ea});
            chk($sformatf("dir_b_k%0d", k), {15'd0, pwm_b}, {15'd0, eb});
        end
        wr(3'd1, 16'hE);
        chk("brake_a", {15'd0, pwm_a}, 16'd1);
        chk("brake_b", {15'd0, pwm_b}, 16'd1);
        wait_until(e0 + 60);
        chk("brake_hold_a", {15'd0, pwm_a}, 16'd1);
        chk("brake_hold_b", {15'd0, pwm_b}, 16'd1);
        wr(3'd1, 16'h6);

        // duty 0, duty PERIOD+1, STATUS write on a boundary
        wr(3'd1, 16'h0);
        wr(3'd3, 16'd0);
        wr(3'd1, 16'h6);
        e0 = edge_cnt;
        for (int k = 11; k <= 31; k++) begin
            wait_until(e0 + k);
            chk($sformatf("zero_a_k%0d", k), {15'd0, pwm_a}, 16'd0);
            chk($sformatf("zero_b_k%0d", k), {15'd0, pwm_b}, 16'd0);
        end
        wr(3'd3, 16'd10);
        for (int k = 41; k <= 61; k++) begin
            wait_until(e0 + k);
            chk($sformatf("full_a_k%0d", k), {15'd0, pwm_a}, 16'd0);
            chk($sformatf("full_b_k%0d", k), {15'd0, pwm_b}, 16'd1);
        end
        wait_until(e0 + 69);
        wr(3'd0, 16'h0);
        rd(3'd0, "status_wr_wins", 16'h0002);
        wait_until(e0 + 85);
        rd(3'd0, "status_next_bnd", 16'h0003);

        // PERIOD rewrite mid-count
        wr(3'd1, 16'h7);
        wr(3'd2, 16'd19);
        w0 = edge_cnt;
        wr(3'd0, 16'h0);
        chk("per_irq_w1", {15'd0, irq}, 16'd0);
        wait_until(w0 + 10);
        chk("per_irq_w10", {15'd0, irq}, 16'd0);
        wait_until(w0 + 11);
        chk("per_irq_w11", {15'd0, irq}, 16'd0);
        wait_until(w0 + 19);
        chk("per_irq_w19", {15'd0, irq}, 16'd0);
        wait_until(w0 + 20);
        chk("per_irq_w20", {15'd0, irq}, 16'd1);

        // enable cleared mid-period
        wait_until(w0 + 21);
        wr(3'd0, 16'h0);
        wait_until(w0 + 24);
        chk("dis_pre_b", {15'd0, pwm_b}, 16'd1);
        wr(3'd1, 16'h5);
        chk("dis_a", {15'd0, pwm_a}, 16'd0);
        chk("dis_b", {15'd0, pwm_b}, 16'd0);
        wait_until(w0 + 60);
        chk("dis_irq", {15'd0, irq}, 16'd0);
        chk("dis_hold_b", {15'd0, pwm_b}, 16'd0);
        rd(3'd5, "dis_duty_kept", 16'd10);
        rd(3'd0, "dis_status", 16'h0000);

        // asynchronous reset mid-period
        wr(3'd1, 16'h7);
        e0 = edge_cnt;
        wait_until(e0 + 2);
        chk("arst_pre_b", {15'd0, pwm_b}, 16'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_a", {15'd0, pwm_a}, 16'd0);
        chk("arst_b", {15'd0, pwm_b}, 16'd0);
        chk("arst_irq", {15'd0, irq}, 16'd0);
        chk("arst_rdata", readdata, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(3'd2, "arst_period", 16'd49999);
        rd(3'd1, "arst_control", 16'd0);
        rd(3'd5, "arst_duty_cur", 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/miniproject_motor_pwm.md
# miniProject_motor_pwm

Avalon-MM slave PWM generator driving the motor H-bridge. Sits in the same Platform Designer system as the interval timer: the timer's periodic interrupt paces the CPU control loop, and the CPU writes new duty targets here. The block produces a registered, period-aligned two-phase PWM (forward/reverse) with optional duty ramping, a direction-change dead period and a period-end interrupt.

## Interface
- No parameters. Data width is fixed at 16 bits and the register map at 3 address bits.
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  3  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  16  write data
- readdata  out  16  registered read data
- irq  out  1  period-end interrupt, level
- pwm_a  out  1  H-bridge forward leg, registered
- pwm_b  out  1  H-bridge reverse leg, registered

## Operation
- Register map (wr = chipselect && !write_n):
  - 0 STATUS: bit0 period_done, bit1 running, bit2 ramp_busy. Any write clears period_done.
  - 1 CONTROL[3:0]: bit0 irq_en, bit1 enable, bit2 dir, bit3 brake.
  - 2 PERIOD: reset 49999.
  - 3 DUTY_TGT: reset 0.
  - 4 RAMP_STEP: reset 0.
  - 5 DUTY_CUR: read-only; writes ignored.
  - 6 and 7 read 0; writes ignored.
- Counter `cnt` (16-bit) counts 0..PERIOD, then wraps to 0. The wrap cycle is `boundary` (running && cnt==PERIOD).
- Counter behaviour when not running:
  - running = CONTROL.enable.
  - While not running: cnt held at 0, pwm_a=pwm_b=0, no boundaries.
- Writing PERIOD forces cnt to 0 next cycle. DUTY_CUR and the active direction are unchanged.
- Raw PWM is `pwm = (cnt < DUTY_CUR)`:
  - DUTY_CUR=0 gives 0 %.
  - DUTY_CUR > PERIOD gives 100 %.
- DUTY_CUR update, at boundary only:
  - If RAMP_STEP==0: DUTY_CUR <= DUTY_TGT.
  - Otherwise DUTY_CUR moves toward DUTY_TGT by RAMP_STEP and saturates exactly at DUTY_TGT (17-bit intermediate, no wrap past 0 or 0xFFFF).
- ramp_busy = (DUTY_CUR != DUTY_TGT).
- Direction handling:
  - `dir_act` loads CONTROL.dir at boundary.
  - When the loaded value differs, the following full period is a dead period: pwm_a=pwm_b=0.
- Output selection (priority order):
  - !running: 00.
  - brake: pwm_a=pwm_b=1 (overrides PWM and dead period while running).
  - dead period: 00.
  - dir_act=0: pwm_a=pwm, pwm_b=0.
  - dir_act=1: pwm_a=0, pwm_b=pwm.
- pwm_a and pwm_b are never both 1 except under brake.
- period_done:
  - Set at each boundary.
  - A STATUS write in the same cycle as a boundary wins, so the bit reads cleared.
- irq = period_done && irq_en, combinational from registers.
- Clearing enable mid-period:
  - cnt <= 0 next cycle; outputs low from the next cycle.
  - DUTY_CUR and dir_act are kept.
  - period_done is not set.

## Timing
- Reset values:
  - readdata=0, irq=0, pwm_a=pwm_b=0.
  - cnt=0, DUTY_CUR=0, dir_act=0, dead period inactive.
  - CONTROL=0, PERIOD=49999, DUTY_TGT=0, RAMP_STEP=0, period_done=0.
- Register writes take effect on the clock edge where wr is sampled. Side effects (cnt reset, clears) are visible the next cycle.
- Read latency is 1 cycle: readdata is updated every clock from the address mux, regardless of chipselect.
- pwm_a/pwm_b are registered, 1 cycle behind the cnt/DUTY_CUR compare.
- PWM period is PERIOD+1 clocks. A new DUTY_CUR governs the period starting at cnt=0 after the boundary.
- enable 0→1: cnt starts at 0. The first boundary occurs PERIOD+1 cycles after the enable write.
- Ramp from 0 to T with step S takes ceil(T/S) boundaries.

## Test plan
- Reset, then read all registers → PERIOD=49999; all others 0; pwm_a=pwm_b=0; irq=0.
- PERIOD=9, DUTY_TGT=3, CONTROL=0x2 → pwm_a high 3 of every 10 clocks; pwm_b=0; period_done=1 after the first boundary; with irq_en=1, irq asserts; STATUS write → irq drops the next cycle.
- Ramp: PERIOD=99, RAMP_STEP=30, DUTY_TGT=100 → DUTY_CUR reads 30, 60, 90, 100, 100 at successive boundaries; ramp_busy clears at 100. Then DUTY_TGT=0 → DUTY_CUR steps 70, 40, 10, 0 (no underflow).
- Direction change while running at duty 5/10: set dir=1 → one full 10-clock period with both legs 0, then pwm_b carries PWM and pwm_a=0. Brake=1 → both legs 1 next cycle.
- Boundaries: DUTY_TGT=0 → legs stay 0; DUTY_TGT=PERIOD+1 → leg constantly 1; STATUS write coincident with boundary → period_done reads 0.
- Mid-operation events:
  - Write PERIOD mid-count → cnt restarts at 0 and the next boundary arrives after the new PERIOD+1 cycles.
  - Clear enable mid-period → outputs 0 next cycle; no irq.
  - Assert reset_n low mid-period → all outputs 0 immediately (asynchronous reset).
